// File: rtl/ext_pkg.sv
// Immediate extension types, width select constants and the extension function.
// Shared by ext_core (S2 datapath) and imm_extend_pipe (stage registers).
package ext_pkg;

    typedef enum logic [1:0] {
        EXT_ZERO = 2'd0,
        EXT_SIGN = 2'd1,
        EXT_HIGH = 2'd2,
        EXT_ONES = 2'd3
    } ext_mode_e;

    // Default field widths for wsel codes 0..3.
    localparam int unsigned EXT_W0 = 4;
    localparam int unsigned EXT_W1 = 6;
    localparam int unsigned EXT_W2 = 8;
    localparam int unsigned EXT_W3 = 12;

    // Internal working width of the extension function; OUT_W must fit.
    localparam int unsigned EXT_MAX_W = 64;

    function automatic int unsigned ext_width(
        input logic [1:0]  wsel,
        input int unsigned w0,
        input int unsigned w1,
        input int unsigned w2,
        input int unsigned w3
    );
        int unsigned w;
        case (wsel)
            2'd0:    w = w0;
            2'd1:    w = w1;
            2'd2:    w = w2;
            default: w = w3;
        endcase
        return w;
    endfunction

    // field must already be masked to w bits. Bits at and above out_w are 0.
    function automatic logic [EXT_MAX_W-1:0] ext_calc(
        input logic [EXT_MAX_W-1:0] field,
        input int unsigned          w,
        input int unsigned          out_w,
        input ext_mode_e            mode
    );
        logic [EXT_MAX_W-1:0] low_mask;
        logic [EXT_MAX_W-1:0] out_mask;
        logic [EXT_MAX_W-1:0] up_mask;
        logic [EXT_MAX_W-1:0] msb_vec;
        logic [EXT_MAX_W-1:0] res;
        low_mask = {EXT_MAX_W{1'b1}} >> (EXT_MAX_W - w);
        out_mask = {EXT_MAX_W{1'b1}} >> (EXT_MAX_W - out_w);
        up_mask  = out_mask & ~low_mask;
        msb_vec  = field >> (w - 1);
        case (mode)
            EXT_ZERO: res = field & low_mask;
            EXT_SIGN: res = msb_vec[0] ? (field | up_mask) : field;
            EXT_HIGH: res = (field << (out_w - w)) & out_mask;
            default:  res = field | up_mask;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ext_core.sv
// Combinational S2 datapath: extends a captured field to OUT_W bits.
// Ports: field (masked raw field), wsel, mode in; data (extended result) out.
module ext_core
    import ext_pkg::*;
#(
    parameter int IN_W  = 12,
    parameter int OUT_W = 16,
    parameter int W0    = 4,
    parameter int W1    = 6,
    parameter int W2    = 8,
    parameter int W3    = 12
) (
    input  logic [IN_W-1:0]  field,
    input  logic [1:0]       wsel,
    input  ext_mode_e        mode,
    output logic [OUT_W-1:0] data
);

    logic [EXT_MAX_W-1:0] wide;
    logic [EXT_MAX_W-1:0] res;

    always_comb begin
        wide = '0;
        wide[IN_W-1:0] = field;
        res = ext_calc(wide, ext_width(wsel, W0, W1, W2, W3), OUT_W, mode);
        data = res[OUT_W-1:0];
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage pipelined immediate extender with valid/ready on both sides.
// Ports: clk, rst; in_valid/in_ready/in_data/in_wsel/in_mode/in_tag;
//        out_valid/out_ready/out_data/out_tag/out_lost; inflight beat count.
module imm_extend_pipe
    import ext_pkg::*;
#(
    parameter int IN_W  = 12,
    parameter int OUT_W = 16,
    parameter int W0    = 4,
    parameter int W1    = 6,
    parameter int W2    = 8,
    parameter int W3    = 12,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_wsel,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_lost,
    output logic [1:0]       inflight
);

    if (OUT_W < IN_W || OUT_W > EXT_MAX_W ||
        W0 < 1 || W0 > IN_W || W1 < 1 || W1 > IN_W ||
        W2 < 1 || W2 > IN_W || W3 < 1 || W3 > IN_W) begin : g_bad_param
        $error("imm_extend_pipe: illegal width parameters");
    end

    logic             s1_valid;
    logic [IN_W-1:0]  s1_field;
    logic             s1_lost;
    ext_mode_e        s1_mode;
    logic [1:0]       s1_wsel;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_valid;
    logic             s2_adv;
    logic             in_fire;
    logic             s1_valid_d;
    logic             s2_valid_d;
    logic [IN_W-1:0]  in_mask;
    logic [OUT_W-1:0] ext_data;

    assign s2_adv    = s1_valid && (!s2_valid || out_ready);
    assign in_ready  = !s1_valid || s2_adv;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_valid;

    assign s1_valid_d = in_fire || (s1_valid && !s2_adv);
    assign s2_valid_d = s2_adv || (s2_valid && !out_ready);

    assign in_mask = {IN_W{1'b1}} >>
        (IN_W - ext_width(in_wsel, W0, W1, W2, W3));

    ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .W0    (W0),
        .W1    (W1),
        .W2    (W2),
        .W3    (W3)
    ) u_core (
        .field (s1_field),
        .wsel  (s1_wsel),
        .mode  (s1_mode),
        .data  (ext_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_field <= '0;
            s1_lost  <= 1'b0;
            s1_mode  <= EXT_ZERO;
            s1_wsel  <= '0;
            s1_tag   <= '0;
            s2_valid <= 1'b0;
            out_data <= '0;
            out_tag  <= '0;
            out_lost <= 1'b0;
            inflight <= '0;
        end else begin
            s1_valid <= s1_valid_d;
            s2_valid <= s2_valid_d;
            // Count reflects the stage occupancy taking effect at this edge.
            inflight <= {1'b0, s1_valid_d} + {1'b0, s2_valid_d};
            if (in_fire) begin
                s1_field <= in_data & in_mask;
                s1_lost  <= |(in_data & ~in_mask);
                s1_mode  <= ext_mode_e'(in_mode);
                s1_wsel  <= in_wsel;
                s1_tag   <= in_tag;
            end
            if (s2_adv) begin
                out_data <= ext_data;
                out_tag  <= s1_tag;
                out_lost <= s1_lost;
            end
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Randomised and directed bench for imm_extend_pipe against an arithmetic model.
// Drives inputs #1 after posedge, samples handshakes just before the next edge.
module tb_imm_extend_pipe;

    localparam int IN_W  = 12;
    localparam int OUT_W = 16;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [1:0]       in_wsel;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_lost;
    logic [1:0]       inflight;

    always #5 clk = ~clk;

    imm_extend_pipe #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .W0    (4),
        .W1    (6),
        .W2    (8),
        .W3    (12),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_wsel   (in_wsel),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_lost  (out_lost),
        .inflight  (inflight)
    );

    typedef struct {
        logic [IN_W-1:0]  data;
        logic [1:0]       wsel;
        logic [1:0]       mode;
        logic [TAG_W-1:0] tag;
        bit               lit;
        logic [OUT_W-1:0] xd;
        logic             xl;
    } stim_t;

    typedef struct {
        logic [OUT_W-1:0] d;
        logic [TAG_W-1:0] t;
        logic             l;
        int               acc;
    } exp_t;

    stim_t sq[$];
    exp_t  eq[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    bit chk_lat = 0;
    bit rnd_mode = 0;
    logic ordy = 1'b1;

    bit               prev_stall = 0;
    logic [OUT_W-1:0] prev_d;
    logic [TAG_W-1:0] prev_t;
    logic             prev_l;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Plain-arithmetic reference: value kept modulo 2^w, upper part added.
    function automatic void model(input logic [IN_W-1:0] d,
                                  input logic [1:0] wsel,
                                  input logic [1:0] mode,
                                  output logic [OUT_W-1:0] r,
                                  output logic l);
        int widths[4] = '{4, 6, 8, 12};
        int w, p, v, top, full;
        w    = widths[wsel];
        p    = 1 << w;
        full = 1 << OUT_W;
        v    = int'(d) % p;
        top  = full - p;
        l    = (int'(d) >= p);
        case (mode)
            2'd0:    r = OUT_W'(v);
            2'd1:    r = OUT_W'((v >= p / 2) ? v + top : v);
            2'd2:    r = OUT_W'(v * (full / p));
            default: r = OUT_W'(v + top);
        endcase
    endfunction

    task automatic push_beat(input logic [IN_W-1:0] d, input logic [1:0] ws,
                             input logic [1:0] md, input logic [TAG_W-1:0] tg,
                             input bit lit, input logic [OUT_W-1:0] xd,
                             input logic xl);
        stim_t s;
        s.data = d; s.wsel = ws; s.mode = md; s.tag = tg;
        s.lit = lit; s.xd = xd; s.xl = xl;
        sq.push_back(s);
    endtask

    task automatic cycle();
        exp_t e;
        logic [OUT_W-1:0] md;
        logic ml;
        if (sq.size() > 0 && (!rnd_mode || $urandom_range(0, 3) != 0)) begin
            in_valid = 1'b1;
            in_data  = sq[0].data;
            in_wsel  = sq[0].wsel;
            in_mode  = sq[0].mode;
            in_tag   = sq[0].tag;
        end else begin
            in_valid = 1'b0;
            in_data  = IN_W'($urandom);
            in_wsel  = 2'($urandom);
            in_mode  = 2'($urandom);
            in_tag   = TAG_W'($urandom);
        end
        out_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : ordy;
        #4;
        if (!rst) begin
            if (prev_stall) begin
                chk("stall_data", 32'(out_data), 32'(prev_d));
                chk("stall_tag", 32'(out_tag), 32'(prev_t));
                chk("stall_lost", 32'(out_lost), 32'(prev_l));
            end
            if (out_valid && out_ready) begin
                if (eq.size() == 0) begin
                    chk("spurious_out", 32'(out_valid), 32'(0));
                end else begin
                    e = eq.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.d));
                    chk("out_tag", 32'(out_tag), 32'(e.t));
                    chk("out_lost", 32'(out_lost), 32'(e.l));
                    if (chk_lat) chk("latency", 32'(cyc - e.acc), 32'(2));
                end
            end
            if (in_valid && in_ready) begin
                if (sq[0].lit) begin
                    md = sq[0].xd;
                    ml = sq[0].xl;
                end else begin
                    model(sq[0].data, sq[0].wsel, sq[0].mode, md, ml);
                end
                e.d = md; e.t = sq[0].tag; e.l = ml; e.acc = cyc;
                eq.push_back(e);
                void'(sq.pop_front());
            end
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_t = out_tag;
            prev_l = out_lost;
        end else begin
            prev_stall = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && (sq.size() > 0 || eq.size() > 0); i++)
            cycle();
        chk("drain_left", 32'(sq.size() + eq.size()), 32'(0));
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0; in_wsel = '0; in_mode = '0; in_tag = '0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        cycle();
        cycle();
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_inflight", 32'(inflight), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));

        // Directed vectors with literal expectations.
        chk_lat = 1; ordy = 1'b1;
        push_beat(12'h00A, 2'd0, 2'd1, 4'h1, 1, 16'hFFFA, 1'b0);
        push_beat(12'h0F5, 2'd2, 2'd0, 4'h2, 1, 16'h00F5, 1'b0);
        push_beat(12'h3F5, 2'd2, 2'd0, 4'h3, 1, 16'h00F5, 1'b1);
        push_beat(12'h0AB, 2'd2, 2'd2, 4'h4, 1, 16'hAB00, 1'b0);
        push_beat(12'h005, 2'd1, 2'd3, 4'h5, 1, 16'hFFC5, 1'b0);
        push_beat(12'h800, 2'd3, 2'd1, 4'h6, 1, 16'hF800, 1'b0);
        drain();

        // Back-to-back stream, tags 0..7.
        for (int i = 0; i < 8; i++)
            push_beat(IN_W'($urandom), 2'($urandom), 2'($urandom),
                      TAG_W'(i), 0, '0, 1'b0);
        drain();

        // Backpressure: 4 beats offered into a stalled output.
        chk_lat = 0; ordy = 1'b0;
        for (int i = 0; i < 4; i++)
            push_beat(IN_W'($urandom), 2'($urandom), 2'($urandom),
                      TAG_W'(8 + i), 0, '0, 1'b0);
        for (int i = 0; i < 4; i++) cycle();
        chk("bp_accepted", 32'(eq.size()), 32'(2));
        chk("bp_inflight", 32'(inflight), 32'(2));
        chk("bp_in_ready", 32'(in_ready), 32'(0));
        ordy = 1'b1;
        drain();

        // Reset with two beats in flight.
        ordy = 1'b0;
        for (int i = 0; i < 3; i++)
            push_beat(IN_W'($urandom), 2'($urandom), 2'($urandom),
                      TAG_W'(i), 0, '0, 1'b0);
        for (int i = 0; i < 3; i++) cycle();
        chk("pre_rst_inflight", 32'(inflight), 32'(2));
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        sq.delete();
        eq.delete();
        chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
        chk("mid_rst_inflight", 32'(inflight), 32'(0));
        chk("mid_rst_out_data", 32'(out_data), 32'(0));
        chk("mid_rst_out_tag", 32'(out_tag), 32'(0));
        chk("mid_rst_in_ready", 32'(in_ready), 32'(1));
        ordy = 1'b1; chk_lat = 1;
        push_beat(12'h0AB, 2'd2, 2'd2, 4'h9, 1, 16'hAB00, 1'b0);
        drain();

        // Random traffic with random backpressure.
        chk_lat = 0; rnd_mode = 1;
        for (int i = 0; i < 300; i++) begin
            if (sq.size() < 3)
                push_beat(IN_W'($urandom), 2'($urandom), 2'($urandom),
                          TAG_W'($urandom), 0, '0, 1'b0);
            cycle();
        end
        rnd_mode = 0; ordy = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate extender for the datapath; successor to the fixed sign/zero extenders.
- Takes a raw immediate field with a field width selected at run time.
- Extends it to OUT_W bits in one of four modes: zero, sign, high-place, ones-fill.
- Sits between the instruction decoder and the ALU operand mux; uses valid/ready handshakes on both sides and carries a tag through.

Parameters:
- IN_W, 12, width of the raw input field bus.
- OUT_W, 16, width of the extended result; must be ≥ IN_W.
- W0, 4, field width for wsel=0.
- W1, 6, field width for wsel=1.
- W2, 8, field width for wsel=2.
- W3, 12, field width for wsel=3. All Wk must be ≥1 and ≤ IN_W; elaboration fails otherwise.
- TAG_W, 4, width of the sideband tag carried alongside the data.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts the input beat this cycle.
- in_data  in  IN_W  raw immediate; the field is in bits [Wk-1:0].
- in_wsel  in  2  field width select (W0..W3).
- in_mode  in  2  0 ZERO, 1 SIGN, 2 HIGH, 3 ONES.
- in_tag  in  TAG_W  sideband, returned unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result.
- out_data  out  OUT_W  extended result.
- out_tag  out  TAG_W  tag of this result.
- out_lost  out  1  input had nonzero bits above the selected field width.
- inflight  out  2  number of beats held in the block (0..2).

Behaviour:
- Transfers: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Pipeline: two register stages, S1 (capture) and S2 (output register).
- Latency: a beat accepted at edge k is presented on out_* after edge k+1, i.e. two cycles from in_valid to out_valid when unstalled.
- Throughput: one beat per cycle when out_ready is held high.
- S1 capture: stores
  - field = in_data masked to Wk bits,
  - lost = OR of in_data[IN_W-1:Wk],
  - mode, wsel, tag.
- S2 extension, computed from S1 contents with Wk = selected width:
  - ZERO: upper OUT_W-Wk bits are 0.
  - SIGN: upper bits equal field[Wk-1].
  - ONES: upper bits are 1.
  - HIGH: out_data = field << (OUT_W-Wk); low bits 0.
  - When Wk = OUT_W, all four modes return the field unchanged.
- Advance rules:
  - s2_adv = s1_valid && (!s2_valid || out_ready).
  - in_ready = !s1_valid || s2_adv. This path is combinational from out_ready; no other combinational in→out paths.
- Stall: while stalled, S1 and S2 hold data, tag and lost unchanged. out_* must stay stable while out_valid && !out_ready.
- Simultaneous events: same-cycle output transfer, S1→S2 move and new input capture must all occur with no bubble and no loss. Order is strictly FIFO.
- inflight = s1_valid + s2_valid, registered, updated every edge.
- Reset: on rst high at an edge, the following are cleared next cycle:
  - s1_valid, s2_valid, inflight = 0,
  - out_data = 0, out_tag = 0, out_lost = 0.
  - In-flight beats are discarded.
  - in_ready = 1 during the first cycle after reset is released.
  - Input transfers presented while rst is high are ignored.
- No illegal encodings: all wsel/mode codes are defined.

Decomposition:
- Package ext_pkg holds:
  - mode enum (EXT_ZERO, EXT_SIGN, EXT_HIGH, EXT_ONES),
  - wsel width constants,
  - a pure function computing the extension from field, width and mode.
- Sub-module ext_core: combinational S2 datapath that instantiates the function, parametrised by OUT_W.
- The handshake and stage registers live in imm_extend_pipe.

Test Plan:
- SIGN, wsel=0, in_data=12'h00A; out_ready=1 → out_data=16'hFFFA two cycles later, out_lost=0.
- ZERO, wsel=2, in_data=12'h0F5 → 16'h00F5, lost=0. Next beat in_data=12'h3F5, same mode/wsel → 16'h00F5, lost=1.
- HIGH, wsel=2, in_data=12'h0AB → 16'hAB00. ONES, wsel=1, in_data=12'h005 → 16'hFFC5. SIGN, wsel=3, in_data=12'h800 → 16'hF800.
- Back-to-back stream: 8 beats with tags 0..7, out_ready=1 → 8 results on consecutive cycles, first at cycle 2, tags in order.
- Backpressure: out_ready=0 for 4 cycles while 4 beats are offered → 2 accepted, in_ready=0, inflight=2, out_data stable. Release → remaining beats drain in order, none lost or duplicated.
- Reset mid-operation: inflight=2, then assert rst for one cycle → next cycle out_valid=0, inflight=0, out_data=0. After release in_ready=1, and a new beat completes normally.
